// File: rtl/poly_solver_pkg.sv
// Shared types for the quadratic root search: state encoding, ALU operations, datapath controls.
// Optional feature macro: POLY_SOLVER_ALL_ROOTS_EN (count every root instead of stopping at the first).
package poly_solver_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [4:0] {
        S_LOAD_A      = 5'd0,
        S_LOAD_A_WAIT = 5'd1,
        S_LOAD_B      = 5'd2,
        S_LOAD_B_WAIT = 5'd3,
        S_LOAD_C      = 5'd4,
        S_LOAD_C_WAIT = 5'd5,
        S_LOAD_Y      = 5'd6,
        S_LOAD_Y_WAIT = 5'd7,
        S_INIT        = 5'd8,
        S_EVAL_0      = 5'd9,
        S_EVAL_1      = 5'd10,
        S_EVAL_2      = 5'd11,
        S_EVAL_3      = 5'd12,
        S_CMP         = 5'd13,
        S_DONE        = 5'd14,
        S_DONE_WAIT   = 5'd15
    } state_t;

    typedef enum logic [2:0] {
        ALU_NOP    = 3'd0,
        ALU_MUL_AX = 3'd1,
        ALU_ADD_B  = 3'd2,
        ALU_MUL_X  = 3'd3,
        ALU_ADD_C  = 3'd4
    } alu_op_t;

    typedef struct packed {
        logic ld_a;
        logic ld_b;
        logic ld_c;
        logic ld_y;
        logic x_clr;
        logic x_inc;
    } dp_ctrl_t;

endpackage

// File: rtl/poly_solver_if.sv
// Operand/result bus of the root solver; root_count exists only with POLY_SOLVER_ALL_ROOTS_EN.
// go is a level strobe: one value is taken per high phase, and the next value needs go low again.
interface poly_solver_if #(parameter int WIDTH = poly_solver_pkg::DEFAULT_WIDTH);

    logic             go;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] x_result;
    logic             found;
    logic             done;
`ifdef POLY_SOLVER_ALL_ROOTS_EN
    logic [WIDTH:0]   root_count;
`endif

    modport master (
        output go, data_in,
`ifdef POLY_SOLVER_ALL_ROOTS_EN
        input  root_count,
`endif
        input  x_result, found, done
    );

    modport slave (
        input  go, data_in,
`ifdef POLY_SOLVER_ALL_ROOTS_EN
        output root_count,
`endif
        output x_result, found, done
    );

endinterface

// File: rtl/poly_solver_datapath.sv
// Horner-form evaluator of A*x^2 + B*x + C = ((A*x) + B)*x + C, one ALU step per cycle,
// with operand registers, candidate counter x and a comparator against Y.
module poly_solver_datapath
    import poly_solver_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] i_data_in,
    input  dp_ctrl_t         i_ctrl,
    input  alu_op_t          i_alu_op,
    output logic [WIDTH-1:0] o_x,
    output logic             o_match,
    output logic             o_x_last
);

    logic [WIDTH-1:0] r_a, r_b, r_c, r_y, r_x, r_t;
    logic [WIDTH-1:0] w_op_a, w_op_b, w_alu;
    logic             w_is_mul;

    // Operand A is the accumulator t except for the first step, which starts from A.
    always_comb begin
        w_op_a = r_t;
        w_op_b = r_x;
        case (i_alu_op)
            ALU_MUL_AX: w_op_a = r_a;
            ALU_ADD_B:  w_op_b = r_b;
            ALU_ADD_C:  w_op_b = r_c;
            default:    ;
        endcase
        w_is_mul = (i_alu_op == ALU_MUL_AX) || (i_alu_op == ALU_MUL_X);
        w_alu    = w_is_mul ? (w_op_a * w_op_b) : (w_op_a + w_op_b);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_a <= '0;
            r_b <= '0;
            r_c <= '0;
            r_y <= '0;
            r_x <= '0;
            r_t <= '0;
        end else begin
            if (i_ctrl.ld_a) r_a <= i_data_in;
            if (i_ctrl.ld_b) r_b <= i_data_in;
            if (i_ctrl.ld_c) r_c <= i_data_in;
            if (i_ctrl.ld_y) r_y <= i_data_in;
            if (i_ctrl.x_clr)      r_x <= '0;
            else if (i_ctrl.x_inc) r_x <= r_x + 1'b1;
            if (i_alu_op != ALU_NOP) r_t <= w_alu;
        end
    end

    assign o_x      = r_x;
    assign o_match  = (r_t == r_y);
    assign o_x_last = &r_x;

endmodule

// File: rtl/poly_solver.sv
// Control FSM for the root search: loads A, B, C, Y with go press/release, then tries x = 0.. upward.
// POLY_SOLVER_ALL_ROOTS_EN: scan every x, keep the first root and count all of them in root_count.
module poly_solver
    import poly_solver_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic              clk,
    input  logic              resetn,
    poly_solver_if.slave      bus,
    output state_t            o_dbg_state
);

    state_t           r_state;
    logic             r_done;
    logic             r_found;
    logic [WIDTH-1:0] r_x_result;
`ifdef POLY_SOLVER_ALL_ROOTS_EN
    logic [WIDTH:0]   r_root_count;
`endif

    dp_ctrl_t         w_ctrl;
    alu_op_t          w_alu_op;
    logic [WIDTH-1:0] w_x;
    logic             w_match;
    logic             w_x_last;
    logic             w_stop;

`ifdef POLY_SOLVER_ALL_ROOTS_EN
    assign w_stop = w_x_last;
`else
    assign w_stop = w_match || w_x_last;
`endif

    always_comb begin
        w_ctrl   = '0;
        w_alu_op = ALU_NOP;
        case (r_state)
            S_LOAD_A: w_ctrl.ld_a  = 1'b1;
            S_LOAD_B: w_ctrl.ld_b  = 1'b1;
            S_LOAD_C: w_ctrl.ld_c  = 1'b1;
            S_LOAD_Y: w_ctrl.ld_y  = 1'b1;
            S_INIT:   w_ctrl.x_clr = 1'b1;
            S_EVAL_0: w_alu_op     = ALU_MUL_AX;
            S_EVAL_1: w_alu_op     = ALU_ADD_B;
            S_EVAL_2: w_alu_op     = ALU_MUL_X;
            S_EVAL_3: w_alu_op     = ALU_ADD_C;
            S_CMP:    w_ctrl.x_inc = !w_stop;
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state      <= S_LOAD_A;
            r_done       <= 1'b0;
            r_found      <= 1'b0;
            r_x_result   <= '0;
`ifdef POLY_SOLVER_ALL_ROOTS_EN
            r_root_count <= '0;
`endif
        end else begin
            case (r_state)
                S_LOAD_A:      if (bus.go)  r_state <= S_LOAD_A_WAIT;
                S_LOAD_A_WAIT: if (!bus.go) r_state <= S_LOAD_B;
                S_LOAD_B:      if (bus.go)  r_state <= S_LOAD_B_WAIT;
                S_LOAD_B_WAIT: if (!bus.go) r_state <= S_LOAD_C;
                S_LOAD_C:      if (bus.go)  r_state <= S_LOAD_C_WAIT;
                S_LOAD_C_WAIT: if (!bus.go) r_state <= S_LOAD_Y;
                S_LOAD_Y:      if (bus.go)  r_state <= S_LOAD_Y_WAIT;
                S_LOAD_Y_WAIT: if (!bus.go) r_state <= S_INIT;
                S_INIT: begin
                    r_found      <= 1'b0;
                    r_x_result   <= '0;
`ifdef POLY_SOLVER_ALL_ROOTS_EN
                    r_root_count <= '0;
`endif
                    r_state      <= S_EVAL_0;
                end
                S_EVAL_0: r_state <= S_EVAL_1;
                S_EVAL_1: r_state <= S_EVAL_2;
                S_EVAL_2: r_state <= S_EVAL_3;
                S_EVAL_3: r_state <= S_CMP;
                S_CMP: begin
`ifdef POLY_SOLVER_ALL_ROOTS_EN
                    if (w_match) begin
                        r_root_count <= r_root_count + 1'b1;
                        if (!r_found) begin
                            r_found    <= 1'b1;
                            r_x_result <= w_x;
                        end
                    end
`else
                    if (w_match) begin
                        r_found    <= 1'b1;
                        r_x_result <= w_x;
                    end
`endif
                    if (w_stop) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= S_EVAL_0;
                    end
                end
                // done is a one-state flag; results stay put until the next S_INIT.
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= bus.go ? S_DONE_WAIT : S_LOAD_A;
                end
                S_DONE_WAIT: if (!bus.go) r_state <= S_LOAD_A;
                default: r_state <= S_LOAD_A;
            endcase
        end
    end

    poly_solver_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clk       (clk),
        .resetn    (resetn),
        .i_data_in (bus.data_in),
        .i_ctrl    (w_ctrl),
        .i_alu_op  (w_alu_op),
        .o_x       (w_x),
        .o_match   (w_match),
        .o_x_last  (w_x_last)
    );

    assign bus.x_result = r_x_result;
    assign bus.found    = r_found;
    assign bus.done     = r_done;
`ifdef POLY_SOLVER_ALL_ROOTS_EN
    assign bus.root_count = r_root_count;
`endif
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_poly_solver.sv
// Bench for poly_solver: spec vectors from a table, random vectors from a brute-force model,
// plus go-hold, go-pulse and mid-search reset sequences. Honors POLY_SOLVER_ALL_ROOTS_EN.
module tb_poly_solver;
    import poly_solver_pkg::*;

    localparam int W        = 8;
    localparam int LAT_NONE = 1 + 5 * (1 << W);

    logic   clk = 1'b0;
    logic   resetn = 1'b0;
    state_t dbg;

    always #5 clk = ~clk;

    poly_solver_if #(.WIDTH(W)) bus ();

    poly_solver #(.WIDTH(W)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .bus         (bus),
        .o_dbg_state (dbg)
    );

    typedef struct packed {
        logic         found;
        logic [W-1:0] x;
        logic [W:0]   cnt;
        logic [15:0]  lat;
    } exp_t;

    typedef struct {
        logic [W-1:0] a, b, c, y;
        logic         found;
        logic [W-1:0] x;
        int           lat;
    } vec_t;

    exp_t exp_q[$];
    vec_t tbl[4];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    // Brute-force reference: first root, number of roots, cycles from S_INIT to done.
    function automatic exp_t model(input logic [W-1:0] a, b, c, y);
        exp_t         e;
        int           first;
        int           cnt;
        logic [W-1:0] xv;
        logic [W-1:0] v;
        first = -1;
        cnt   = 0;
        for (int x = 0; x < (1 << W); x++) begin
            xv = x[W-1:0];
            v  = a * xv * xv + b * xv + c;
            if (v == y) begin
                cnt++;
                if (first < 0) first = x;
            end
        end
        e       = '0;
        e.found = (first >= 0);
        e.x     = (first >= 0) ? first[W-1:0] : '0;
        e.cnt   = cnt[W:0];
`ifdef POLY_SOLVER_ALL_ROOTS_EN
        e.lat   = 16'(LAT_NONE);
`else
        e.lat   = (first >= 0) ? 16'(1 + 5 * (first + 1)) : 16'(LAT_NONE);
`endif
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_value(input logic [W-1:0] v);
        bus.data_in = v;
        bus.go      = 1'b1;
        tick();
        bus.go      = 1'b0;
        bus.data_in = W'($urandom_range(0, 255));
        tick();
    endtask

    task automatic load_all(input logic [W-1:0] a, b, c, y);
        load_value(a);
        load_value(b);
        load_value(c);
        load_value(y);
    endtask

    // Called with the DUT in S_INIT; counts edges until done, then compares against the queue head.
    task automatic wait_done(input string tag, input bit pulse_go);
        int   lat;
        bit   seen;
        exp_t e;
        lat  = 0;
        seen = 1'b0;
        for (int n = 1; n <= LAT_NONE + 100; n++) begin
            if (pulse_go && n < 20) bus.go = 1'($urandom_range(0, 1));
            else bus.go = 1'b0;
            tick();
            if (bus.done) begin
                lat  = n;
                seen = 1'b1;
                break;
            end
        end
        bus.go = 1'b0;
        e = exp_q.pop_front();
        check({tag, " done_seen"}, int'(seen), 1);
        check({tag, " found"}, int'(bus.found), int'(e.found));
        check({tag, " x_result"}, int'(bus.x_result), int'(e.x));
        check({tag, " latency"}, lat, int'(e.lat));
`ifdef POLY_SOLVER_ALL_ROOTS_EN
        check({tag, " root_count"}, int'(bus.root_count), int'(e.cnt));
`endif
        tick();
        check({tag, " state_after"}, int'(dbg), int'(S_LOAD_A));
        check({tag, " done_pulse"}, int'(bus.done), 0);
        check({tag, " x_persist"}, int'(bus.x_result), int'(e.x));
        check({tag, " found_persist"}, int'(bus.found), int'(e.found));
    endtask

    task automatic run_vec(input string tag, input logic [W-1:0] a, b, c, y, input exp_t e);
        exp_q.push_back(e);
        load_all(a, b, c, y);
        wait_done(tag, 1'b0);
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t         e;
        exp_t         m;
        logic [W-1:0] ra, rb, rc, ry, rx;
        bit           hit;

        bus.go      = 1'b0;
        bus.data_in = '0;
        repeat (3) tick();
        check("reset state", int'(dbg), int'(S_LOAD_A));
        check("reset done", int'(bus.done), 0);
        check("reset found", int'(bus.found), 0);
        check("reset x_result", int'(bus.x_result), 0);
        resetn = 1'b1;
        tick();

        tbl[0] = '{a: 8'd0, b: 8'd0, c: 8'd7, y: 8'd7,    found: 1'b1, x: 8'd0, lat: 6};
        tbl[1] = '{a: 8'd2, b: 8'd3, c: 8'd1, y: 8'h1C,   found: 1'b1, x: 8'd3, lat: 21};
        tbl[2] = '{a: 8'd1, b: 8'd0, c: 8'd0, y: 8'h19,   found: 1'b1, x: 8'd5, lat: 31};
        tbl[3] = '{a: 8'd0, b: 8'd0, c: 8'd1, y: 8'd2,    found: 1'b0, x: 8'd0, lat: LAT_NONE};

        for (int i = 0; i < 4; i++) begin
            e       = '0;
            e.found = tbl[i].found;
            e.x     = tbl[i].x;
            e.lat   = 16'(tbl[i].lat);
`ifdef POLY_SOLVER_ALL_ROOTS_EN
            m       = model(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].y);
            e.lat   = 16'(LAT_NONE);
            e.cnt   = m.cnt;
`endif
            run_vec($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].y, e);
        end

`ifdef POLY_SOLVER_ALL_ROOTS_EN
        m = model(8'd1, 8'd0, 8'd0, 8'h19);
        check("model x^2=0x19 count", int'(m.cnt), 4);
`endif

        // Random coefficients; Y is usually taken from a random x so a root is likely to exist.
        for (int i = 0; i < 4; i++) begin
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(0, 255));
            rc = W'($urandom_range(0, 255));
            rx = W'($urandom_range(0, 255));
            ry = (i == 3) ? W'($urandom_range(0, 255)) : W'(ra * rx * rx + rb * rx + rc);
            run_vec($sformatf("rand%0d", i), ra, rb, rc, ry, model(ra, rb, rc, ry));
        end

        // go held high for 50 cycles in the A load: later data_in values must not land anywhere.
        e = model(8'd1, 8'd0, 8'd0, 8'h19);
        exp_q.push_back(e);
        bus.data_in = 8'd1;
        bus.go      = 1'b1;
        tick();
        for (int n = 1; n < 50; n++) begin
            bus.data_in = W'($urandom_range(0, 255));
            tick();
        end
        check("hold parked", int'(dbg), int'(S_LOAD_A_WAIT));
        bus.go = 1'b0;
        tick();
        check("hold release", int'(dbg), int'(S_LOAD_B));
        load_value(8'd0);
        load_value(8'd0);
        load_value(8'h19);
        wait_done("hold", 1'b0);

        exp_q.push_back(model(8'd2, 8'd3, 8'd1, 8'h1C));
        load_all(8'd2, 8'd3, 8'd1, 8'h1C);
        wait_done("pulse", 1'b1);

        // Reset during S_EVAL_2 of a long search, then a fresh load.
        load_all(8'd0, 8'd0, 8'd1, 8'd2);
        hit = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (dbg == S_EVAL_2) begin
                hit = 1'b1;
                break;
            end
            tick();
        end
        check("reach eval2", int'(hit), 1);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        check("midreset state", int'(dbg), int'(S_LOAD_A));
        check("midreset done", int'(bus.done), 0);
        check("midreset found", int'(bus.found), 0);
        check("midreset x_result", int'(bus.x_result), 0);
        run_vec("post_reset", 8'd2, 8'd3, 8'd1, 8'h1C, model(8'd2, 8'd3, 8'd1, 8'h1C));

        check("queue drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
